// File: rtl/exemplo_controlador_param.sv
// exemplo_controlador_param: IDLE/LOAD/COMPUTE/END sequencing controller with a
// programmable run length. A level-sensitive start in IDLE latches len_i; the
// datapath enable is then high for exactly len_q cycles, followed by END.
//
// Optional build macro: CTRL_AUTO_RESTART_EN -- when defined, END with the start
// request still high restarts after one END cycle, re-latching len_i.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous reset, active low
//   strt_cmpt_i  start request, level-sensitive
//   len_i        run length in cycles, sampled when a start is accepted
//   abort_i      synchronous abort, honoured in LOAD and COMPUTE only
//   state_o      current state (0 idle, 1 load, 2 compute, 3 end)
//   busy_o       state is not idle
//   cmpt_en_o    datapath enable, high exactly while in COMPUTE
//   cnt_o        cycles completed in the current run
//   done_o       one-cycle pulse in the first END cycle
//   err_o        one-cycle pulse when a zero-length start is rejected
module exemplo_controlador_param #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strt_cmpt_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             abort_i,
  output logic [1:0]       state_o,
  output logic             busy_o,
  output logic             cmpt_en_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StEnd     = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             last_cycle;

  // len_q is never zero in COMPUTE, so the subtraction cannot underflow there.
  assign last_cycle = (cnt_q == (len_q - CntOne));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (strt_cmpt_i) begin
          if (len_i != '0) begin
            len_d   = len_i;
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = abort_i ? StIdle : StCompute;
      end
      StCompute: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
          if (last_cycle) begin
            done_d  = 1'b1;
            state_d = StEnd;
          end
        end
      end
      StEnd: begin
        if (!strt_cmpt_i) begin
          state_d = StIdle;
        end
`ifdef CTRL_AUTO_RESTART_EN
        else if (len_i != '0) begin
          len_d   = len_i;
          state_d = StLoad;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign state_o   = state_q;
  assign busy_o    = (state_q != StIdle);
  assign cmpt_en_o = (state_q == StCompute);
  assign cnt_o     = cnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule
